i2c_passthru_bit_tx: RTL and testbench
======================================

// Module: i2c_passthru_bit_tx
// PURPOSE
// Bit-level transmitter for one side of the I2C passthrough. For every bit started by the
// rxtx controller, it drives the receiving channel's SDA with the bit captured on the other
// channel, stretching that channel's SCL low until the bit is known and set up. It then
// reports completion on o_tx_done. One instance exists per channel; the controller selects
// the active one.
// PARAMETERS
// HOLD_CYC   4  cycles SDA keeps its previous value after SCL falls (tHD;DAT)
// SETUP_CYC  8  cycles new SDA is stable before SCL stretch is released (tSU;DAT)
// CNT_W      8  width of timing counter; HOLD_CYC and SETUP_CYC must be < 2**CNT_W
// PORTS
// i_clk            in   1  system clock; all logic on rising edge
// i_rst            in   1  synchronous reset, active-high
// i_start          in   1  1-cycle pulse from controller: transmit next bit
// i_abort          in   1  start/stop seen or direction change: release lines now
// i_sda_bit        in   1  bit value captured by the opposite-channel receiver
// i_sda_bit_valid  in   1  i_sda_bit is valid for the current bit
// i_scl            in   1  synchronised SCL of the driven channel
// i_sda            in   1  synchronised SDA of the driven channel
// o_sda_oe         out  1  1 = pull SDA low; 0 = release (open drain)
// o_scl_oe         out  1  1 = hold SCL low (clock stretch)
// o_tx_done        out  1  1 = idle/bit complete; 0 = bit in progress
// o_bit_err        out  1  sticky: released SDA (bit=1) read low while SCL high
// BEHAVIOUR
// Reset/abort: state=IDLE, o_sda_oe=0, o_scl_oe=0, o_tx_done=1, o_bit_err=0, counter=0.
// - i_rst has priority over i_abort. i_abort has priority over i_start.
// - Both take effect on the next clock edge from any state.
// States: IDLE, WAIT_LOW, HOLD, WAIT_BIT, SETUP, WAIT_HIGH.
// IDLE: o_tx_done=1; o_sda_oe keeps its last value (the bit stays driven through SCL high).
// - i_start=1 -> WAIT_LOW, and o_tx_done=0 on the next cycle.
// WAIT_LOW: wait for i_scl=0.
// - On i_scl=0: o_scl_oe=1 on the next cycle, counter cleared.
// - Next state is HOLD if HOLD_CYC>0, otherwise WAIT_BIT.
// HOLD: o_sda_oe unchanged; counter increments each cycle; at counter==HOLD_CYC-1 -> WAIT_BIT.
// WAIT_BIT: o_scl_oe=1.
// - When i_sda_bit_valid=1: o_sda_oe <= ~i_sda_bit, counter cleared.
// - Next state is SETUP if SETUP_CYC>0, otherwise WAIT_HIGH.
// SETUP: counter increments each cycle; at counter==SETUP_CYC-1 -> WAIT_HIGH with o_scl_oe=0.
// WAIT_HIGH: o_scl_oe=0; wait for i_scl=1 (peer may stretch for any time, no timeout).
// - On i_scl=1: o_tx_done=1 next cycle, state -> IDLE.
// - If o_sda_oe=0 and i_sda=0 on that cycle, set o_bit_err.
// i_start outside IDLE is ignored; the bit in flight completes unchanged.
// o_bit_err clears only on i_rst or i_abort.
// Latency: i_scl fall -> o_scl_oe=1 in 1 cycle.
// With valid data already present, o_scl_oe release occurs HOLD_CYC+SETUP_CYC+1 cycles after o_scl_oe rises.
// o_sda_oe never changes while o_scl_oe=0 and i_scl=1, except on i_rst/i_abort.
// Counter never wraps; it clears on every state entry.
// TESTING
// 1. Reset: i_rst=1 for 2 cycles -> o_sda_oe=0, o_scl_oe=0, o_tx_done=1, o_bit_err=0.
// 2. Bit 0, data ready: i_start, i_sda_bit_valid=1, i_sda_bit=0, i_scl falls ->
//    o_scl_oe=1 for 13 cycles, o_sda_oe=1 from cycle 5; o_tx_done=1 one cycle after i_scl=1.
// 3. Late data: i_sda_bit_valid held 0 for 50 cycles after HOLD ->
//    o_scl_oe stays 1 and o_sda_oe unchanged; release occurs 8 cycles after valid rises.
// 4. Abort mid-SETUP: i_abort=1 -> next cycle o_sda_oe=0, o_scl_oe=0, o_tx_done=1, state IDLE.
// 5. Bit error: i_sda_bit=1 and bus SDA forced low when SCL rises -> o_bit_err=1,
//    held through the next i_start until i_abort.
// 6. HOLD_CYC=0, SETUP_CYC=0: -> o_scl_oe asserted exactly 2 cycles per bit.
//    A second i_start during WAIT_HIGH is ignored.

Source files
------------

// File: rtl/i2c_passthru_bit_tx.sv
// i2c_passthru_bit_tx
// Bit-level transmitter for one channel of the I2C passthrough. For each bit the
// controller starts, it stretches SCL low once the bus clock falls. It keeps the old
// SDA level for the hold time, then drives the bit captured on the opposite channel.
// After the setup time it releases SCL and reports completion once SCL is seen high.
// A released SDA (bit = 1) that reads low while SCL is high raises a sticky bit error.
module i2c_passthru_bit_tx #(
  parameter int HOLD_CYC  = 4,
  parameter int SETUP_CYC = 8,
  parameter int CNT_W     = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_abort,
  input  logic i_sda_bit,
  input  logic i_sda_bit_valid,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda_oe,
  output logic o_scl_oe,
  output logic o_tx_done,
  output logic o_bit_err
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOW,
    HOLD,
    WAIT_BIT,
    SETUP,
    WAIT_HIGH
  } state_t;

  // A zero-length hold or setup phase skips its state entirely.
  localparam bit              HAS_HOLD   = (HOLD_CYC > 0);
  localparam bit              HAS_SETUP  = (SETUP_CYC > 0);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sda_oe_q, sda_oe_d;
  logic             scl_oe_q, scl_oe_d;
  logic             tx_done_q, tx_done_d;
  logic             bit_err_q, bit_err_d;

  // Next-state and next-output logic; abort forces the idle/released condition.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sda_oe_d  = sda_oe_q;
    scl_oe_d  = scl_oe_q;
    tx_done_d = tx_done_q;
    bit_err_d = bit_err_q;

    if (i_abort) begin
      state_d   = IDLE;
      cnt_d     = '0;
      sda_oe_d  = 1'b0;
      scl_oe_d  = 1'b0;
      tx_done_d = 1'b1;
      bit_err_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_done_d = 1'b1;
          scl_oe_d  = 1'b0;
          if (i_start) begin
            state_d   = WAIT_LOW;
            tx_done_d = 1'b0;
            cnt_d     = '0;
          end
        end

        WAIT_LOW: begin
          if (!i_scl) begin
            scl_oe_d = 1'b1;
            cnt_d    = '0;
            state_d  = HAS_HOLD ? HOLD : WAIT_BIT;
          end
        end

        HOLD: begin
          scl_oe_d = 1'b1;
          if (cnt_q == HOLD_LAST) begin
            cnt_d   = '0;
            state_d = WAIT_BIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        WAIT_BIT: begin
          scl_oe_d = 1'b1;
          if (i_sda_bit_valid) begin
            sda_oe_d = ~i_sda_bit;
            cnt_d    = '0;
            state_d  = HAS_SETUP ? SETUP : WAIT_HIGH;
          end
        end

        SETUP: begin
          if (cnt_q == SETUP_LAST) begin
            cnt_d    = '0;
            scl_oe_d = 1'b0;
            state_d  = WAIT_HIGH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        WAIT_HIGH: begin
          scl_oe_d = 1'b0;
          if (i_scl) begin
            tx_done_d = 1'b1;
            state_d   = IDLE;
            if (!sda_oe_q && !i_sda) begin
              bit_err_d = 1'b1;
            end
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sda_oe_q  <= 1'b0;
      scl_oe_q  <= 1'b0;
      tx_done_q <= 1'b1;
      bit_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sda_oe_q  <= sda_oe_d;
      scl_oe_q  <= scl_oe_d;
      tx_done_q <= tx_done_d;
      bit_err_q <= bit_err_d;
    end
  end

  assign o_sda_oe  = sda_oe_q;
  assign o_scl_oe  = scl_oe_q;
  assign o_tx_done = tx_done_q;
  assign o_bit_err = bit_err_q;

endmodule

// File: tb/tb_i2c_passthru_bit_tx.sv
// tb_i2c_passthru_bit_tx
// Drives two transmitters (default timing and zero hold/setup) from shared stimulus.
// The bus lines are modelled as wired-AND of the bench master and the DUT drivers.
module tb_i2c_passthru_bit_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort, sda_bit, sda_valid, scl_m, sda_m, sda_force;

  logic m_sda_oe, m_scl_oe, m_done, m_err, m_scl, m_sda;
  logic z_sda_oe, z_scl_oe, z_done, z_err, z_scl, z_sda;

  // Open-drain bus: a line is high only if nobody pulls it low.
  assign m_scl = scl_m & ~m_scl_oe;
  assign m_sda = sda_m & ~m_sda_oe & ~sda_force;
  assign z_scl = scl_m & ~z_scl_oe;
  assign z_sda = sda_m & ~z_sda_oe & ~sda_force;

  i2c_passthru_bit_tx #(.HOLD_CYC(4), .SETUP_CYC(8), .CNT_W(8)) dut_main (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_sda_bit(sda_bit), .i_sda_bit_valid(sda_valid), .i_scl(m_scl), .i_sda(m_sda),
    .o_sda_oe(m_sda_oe), .o_scl_oe(m_scl_oe), .o_tx_done(m_done), .o_bit_err(m_err)
  );

  i2c_passthru_bit_tx #(.HOLD_CYC(0), .SETUP_CYC(0), .CNT_W(8)) dut_zero (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_sda_bit(sda_bit), .i_sda_bit_valid(sda_valid), .i_scl(z_scl), .i_sda(z_sda),
    .o_sda_oe(z_sda_oe), .o_scl_oe(z_scl_oe), .o_tx_done(z_done), .o_bit_err(z_err)
  );

  typedef struct {
    string name;
    logic  st, ab, bt, vl, sm, fl;
    logic  e_sda, e_scl, e_done, e_err;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void addVec(string nm, logic st, logic ab, logic bt, logic vl,
                                 logic sm, logic fl, logic e_sda, logic e_scl,
                                 logic e_done, logic e_err);
    vec_t v;
    v.name = nm; v.st = st; v.ab = ab; v.bt = bt; v.vl = vl; v.sm = sm; v.fl = fl;
    v.e_sda = e_sda; v.e_scl = e_scl; v.e_done = e_done; v.e_err = e_err;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input logic st, input logic ab, input logic bt,
                               input logic vl, input logic sm, input logic fl);
    start     = st;
    abort     = ab;
    sda_bit   = bt;
    sda_valid = vl;
    scl_m     = sm;
    sda_force = fl;
  endtask

  task automatic checkOutput(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkMain(input string tag, input logic e_sda, input logic e_scl,
                           input logic e_done, input logic e_err);
    checkOutput({tag, ".sda_oe"}, m_sda_oe, e_sda);
    checkOutput({tag, ".scl_oe"}, m_scl_oe, e_scl);
    checkOutput({tag, ".tx_done"}, m_done, e_done);
    checkOutput({tag, ".bit_err"}, m_err, e_err);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a bit on the main DUT and step until its SCL stretch has risen and fallen.
  task automatic runToRelease(input string tag);
    bit seen_hi;
    bit released;
    seen_hi  = 1'b0;
    released = 1'b0;
    applyStimulus(1'b1, 1'b0, sda_bit, sda_valid, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 40 && !released; i++) begin
      tick();
      if (m_scl_oe) seen_hi = 1'b1;
      else if (seen_hi) released = 1'b1;
    end
    if (!released) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL %s.timeout: got no scl release, expected release within 40 cycles", tag);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hi_cnt;
    sda_m = 1'b1;
    rst   = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset
    $display("[TB] reset");
    tick();
    tick();
    rst = 1'b0;
    checkMain("reset", 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("reset.zero.scl_oe", z_scl_oe, 1'b0);
    checkOutput("reset.zero.tx_done", z_done, 1'b1);

    // Bit 0 with data ready: stretch 13 cycles, SDA pulled from the 5th cycle
    $display("[TB] bit 0, data ready");
    addVec("b0.start",     1, 0, 0, 1, 1, 0,  0, 0, 0, 0);
    addVec("b0.scl_fall",  0, 0, 0, 1, 0, 0,  0, 1, 0, 0);
    for (int i = 0; i < 4; i++)
      addVec("b0.hold",    0, 0, 0, 1, 0, 0,  0, 1, 0, 0);
    addVec("b0.drive",     0, 0, 0, 1, 0, 0,  1, 1, 0, 0);
    for (int i = 0; i < 7; i++)
      addVec("b0.setup",   0, 0, 0, 1, 0, 0,  1, 1, 0, 0);
    addVec("b0.release",   0, 0, 0, 1, 0, 0,  1, 0, 0, 0);
    addVec("b0.done",      0, 0, 0, 1, 1, 0,  1, 0, 1, 0);
    addVec("b0.idle_keep", 0, 0, 0, 1, 0, 0,  1, 0, 1, 0);
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].st, vecs[i].ab, vecs[i].bt, vecs[i].vl, vecs[i].sm, vecs[i].fl);
      tick();
      checkMain($sformatf("%s[%0d]", vecs[i].name, i),
                vecs[i].e_sda, vecs[i].e_scl, vecs[i].e_done, vecs[i].e_err);
    end

    // Late data: stretch holds, SDA keeps its old level, release 8 cycles after valid
    $display("[TB] late data");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("late.start.tx_done", m_done, 1'b0);
    start = 1'b0;
    tick();
    checkOutput("late.stretch", m_scl_oe, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 50; i++) begin
      tick();
      checkOutput($sformatf("late.wait[%0d].scl_oe", i), m_scl_oe, 1'b1);
      checkOutput($sformatf("late.wait[%0d].sda_oe", i), m_sda_oe, 1'b1);
    end
    sda_valid = 1'b1;
    tick();
    checkOutput("late.valid.sda_oe", m_sda_oe, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      checkOutput($sformatf("late.setup[%0d].scl_oe", i), m_scl_oe, (i < 8) ? 1'b1 : 1'b0);
    end
    scl_m = 1'b1;
    tick();
    checkMain("late.done", 1'b0, 1'b0, 1'b1, 1'b0);
    scl_m = 1'b0;
    tick();

    // Abort during SETUP
    $display("[TB] abort in setup");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checkOutput("abort.pre.sda_oe", m_sda_oe, 1'b1);
    tick();
    tick();
    abort = 1'b1;
    tick();
    checkMain("abort", 1'b0, 1'b0, 1'b1, 1'b0);
    abort = 1'b0;
    tick();
    checkMain("abort.idle", 1'b0, 1'b0, 1'b1, 1'b0);

    // Bit error: released SDA held low by the bus while SCL rises
    $display("[TB] bit error");
    sda_bit   = 1'b1;
    sda_valid = 1'b1;
    runToRelease("err");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    checkMain("err.flag", 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("err.next.tx_done", m_done, 1'b0);
    checkOutput("err.next.bit_err", m_err, 1'b1);
    tick();
    tick();
    checkOutput("err.held.bit_err", m_err, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkMain("err.cleared", 1'b0, 1'b0, 1'b1, 1'b0);

    // Zero hold/setup: 2-cycle stretch, second start in WAIT_HIGH ignored
    $display("[TB] zero hold/setup");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    hi_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      start = (k == 0 || k == 3);
      scl_m = (k == 4);
      tick();
      if (z_scl_oe) hi_cnt++;
      if (k == 4) checkOutput("zero.done", z_done, 1'b1);
    end
    start = 1'b0;
    checkInt("zero.stretch_cycles", hi_cnt, 2);
    checkOutput("zero.ignored.scl_oe", z_scl_oe, 1'b0);
    checkOutput("zero.ignored.tx_done", z_done, 1'b1);
    checkOutput("zero.sda_oe", z_sda_oe, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
